// File: rtl/timer_ctrl.sv
// Programmable period timer with a config handshake, one-shot or periodic mode,
// a registered tick pulse and a saturating completed-period counter.
module timer_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [31:0] cfg_period,
    input  logic        cfg_oneshot,
    input  logic        start,
    input  logic        stop,
    output logic        tick,
    output logic        busy,
    output logic [31:0] count,
    output logic [15:0] ticks
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] count_reg, count_next;
    logic [15:0] ticks_reg, ticks_next;
    logic        tick_reg, tick_next;
    logic [31:0] period_reg, period_next;
    logic        oneshot_reg, oneshot_next;
    logic        last_cycle;

    assign last_cycle = (count_reg == period_reg - 32'd1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            count_reg   <= 32'd0;
            ticks_reg   <= 16'd0;
            tick_reg    <= 1'b0;
            period_reg  <= 32'd0;
            oneshot_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            count_reg   <= count_next;
            ticks_reg   <= ticks_next;
            tick_reg    <= tick_next;
            period_reg  <= period_next;
            oneshot_reg <= oneshot_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        count_next   = count_reg;
        ticks_next   = ticks_reg;
        tick_next    = 1'b0;
        period_next  = period_reg;
        oneshot_next = oneshot_reg;

        case (state_reg)
            IDLE: begin
                if (cfg_valid) begin
                    period_next  = cfg_period;
                    oneshot_next = cfg_oneshot;
                end
                // A start uses the period already latched, not one offered on the same edge.
                if (start && !stop && (period_reg != 32'd0)) begin
                    state_next = RUN;
                    count_next = 32'd0;
                    ticks_next = 16'd0;
                end
            end
            RUN: begin
                if (stop) begin
                    state_next = IDLE;
                end else if (last_cycle) begin
                    tick_next = 1'b1;
                    if (ticks_reg != 16'hFFFF) begin
                        ticks_next = ticks_reg + 16'd1;
                    end
                    if (oneshot_reg) begin
                        state_next = DONE;
                    end else begin
                        count_next = 32'd0;
                    end
                end else begin
                    count_next = count_reg + 32'd1;
                end
            end
            DONE: begin
                if (stop) begin
                    state_next = IDLE;
                end else if (start) begin
                    state_next = RUN;
                    count_next = 32'd0;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign cfg_ready = (state_reg == IDLE);
    assign busy      = (state_reg == RUN);
    assign tick      = tick_reg;
    assign count     = count_reg;
    assign ticks     = ticks_reg;

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed bench for timer_ctrl; every expected value below is worked out by hand
// from the edge count since the start command.
module tb_timer_ctrl;

    logic        clk;
    logic        reset;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [31:0] cfg_period;
    logic        cfg_oneshot;
    logic        start;
    logic        stop;
    logic        tick;
    logic        busy;
    logic [31:0] count;
    logic [15:0] ticks;

    int checks_cnt;
    int fail_cnt;

    timer_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_period (cfg_period),
        .cfg_oneshot(cfg_oneshot),
        .start      (start),
        .stop       (stop),
        .tick       (tick),
        .busy       (busy),
        .count      (count),
        .ticks      (ticks)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end else begin
            $display("ok   %s = %0d", tag, obs);
        end
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic configure(input logic [31:0] per, input logic os);
        cfg_valid   = 1'b1;
        cfg_period  = per;
        cfg_oneshot = os;
        step(1);
        cfg_valid   = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    initial begin
        checks_cnt  = 0;
        fail_cnt    = 0;
        reset       = 1'b1;
        cfg_valid   = 1'b0;
        cfg_period  = 32'd0;
        cfg_oneshot = 1'b0;
        start       = 1'b0;
        stop        = 1'b0;

        // Reset state
        step(3);
        reset = 1'b0;
        check_eq("rst_count", count, 0);
        check_eq("rst_ticks", {16'd0, ticks}, 0);
        check_eq("rst_tick", {31'd0, tick}, 0);
        check_eq("rst_busy", {31'd0, busy}, 0);
        check_eq("rst_cfg_ready", {31'd0, cfg_ready}, 1);

        // Start without any configuration is ignored
        pulse_start();
        for (int i = 0; i < 10; i++) begin
            check_eq("nocfg_busy", {31'd0, busy}, 0);
            step(1);
        end
        check_eq("nocfg_count", count, 0);
        check_eq("nocfg_ticks", {16'd0, ticks}, 0);

        // Periodic, period 5, 200 RUN edges
        configure(32'd5, 1'b0);
        pulse_start();
        check_eq("p5_busy", {31'd0, busy}, 1);
        check_eq("p5_count0", count, 0);
        check_eq("p5_cfg_ready", {31'd0, cfg_ready}, 0);
        for (int i = 1; i <= 200; i++) begin
            step(1);
            check_eq("p5_count", count, i % 5);
            check_eq("p5_tick", {31'd0, tick}, (i % 5 == 0) ? 1 : 0);
        end
        check_eq("p5_ticks", {16'd0, ticks}, 40);
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        check_eq("p5_stop_busy", {31'd0, busy}, 0);
        check_eq("p5_stop_ticks", {16'd0, ticks}, 40);

        // One-shot, period 4
        configure(32'd4, 1'b1);
        pulse_start();
        check_eq("os_ticks_clr", {16'd0, ticks}, 0);
        for (int i = 1; i <= 3; i++) begin
            step(1);
            check_eq("os_count", count, i);
            check_eq("os_tick", {31'd0, tick}, 0);
        end
        step(1);
        check_eq("os_tick4", {31'd0, tick}, 1);
        check_eq("os_busy4", {31'd0, busy}, 0);
        check_eq("os_count4", count, 3);
        check_eq("os_ticks4", {16'd0, ticks}, 1);
        step(5);
        check_eq("os_done_tick", {31'd0, tick}, 0);
        check_eq("os_done_count", count, 3);
        check_eq("os_done_ready", {31'd0, cfg_ready}, 0);
        pulse_start();
        check_eq("os_re_busy", {31'd0, busy}, 1);
        check_eq("os_re_count", count, 0);
        check_eq("os_re_ticks", {16'd0, ticks}, 1);
        step(3);
        check_eq("os_re_tick3", {31'd0, tick}, 0);
        step(1);
        check_eq("os_re_tick4", {31'd0, tick}, 1);
        check_eq("os_re_ticks4", {16'd0, ticks}, 2);
        start = 1'b1;
        stop  = 1'b1;
        step(1);
        start = 1'b0;
        stop  = 1'b0;
        check_eq("os_ss_ready", {31'd0, cfg_ready}, 1);
        check_eq("os_ss_busy", {31'd0, busy}, 0);
        check_eq("os_ss_count", count, 3);
        check_eq("os_ss_ticks", {16'd0, ticks}, 2);

        // Periodic, period 10; config offered during RUN must be dropped
        configure(32'd10, 1'b0);
        pulse_start();
        step(2);
        cfg_valid  = 1'b1;
        cfg_period = 32'd3;
        step(1);
        cfg_valid  = 1'b0;
        check_eq("p10_ready_run", {31'd0, cfg_ready}, 0);
        step(3);
        check_eq("p10_count6", count, 6);
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        check_eq("p10_stop_busy", {31'd0, busy}, 0);
        check_eq("p10_stop_count", count, 6);
        check_eq("p10_stop_ready", {31'd0, cfg_ready}, 1);
        pulse_start();
        check_eq("p10_restart_count", count, 0);
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(2);
        check_eq("p10_start_ign", count, 3);
        step(6);
        check_eq("p10_count9", count, 9);
        check_eq("p10_tick9", {31'd0, tick}, 0);
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        check_eq("p10_stopwin_tick", {31'd0, tick}, 0);
        check_eq("p10_stopwin_ticks", {16'd0, ticks}, 0);
        check_eq("p10_stopwin_count", count, 9);
        check_eq("p10_stopwin_busy", {31'd0, busy}, 0);
        pulse_start();
        step(2);
        start = 1'b1;
        stop  = 1'b1;
        step(1);
        start = 1'b0;
        stop  = 1'b0;
        check_eq("run_ss_busy", {31'd0, busy}, 0);
        check_eq("run_ss_count", count, 2);

        // Reset mid-RUN, period 8
        configure(32'd8, 1'b0);
        pulse_start();
        step(5);
        check_eq("p8_count5", count, 5);
        reset = 1'b1;
        start = 1'b1;
        step(1);
        reset = 1'b0;
        start = 1'b0;
        check_eq("mrst_count", count, 0);
        check_eq("mrst_ticks", {16'd0, ticks}, 0);
        check_eq("mrst_tick", {31'd0, tick}, 0);
        check_eq("mrst_busy", {31'd0, busy}, 0);
        check_eq("mrst_ready", {31'd0, cfg_ready}, 1);
        pulse_start();
        check_eq("mrst_period_clr", {31'd0, busy}, 0);

        // Period 1 periodic: tick every cycle, ticks saturates
        configure(32'd1, 1'b0);
        pulse_start();
        check_eq("p1_tick0", {31'd0, tick}, 0);
        check_eq("p1_busy", {31'd0, busy}, 1);
        step(1);
        check_eq("p1_tick1", {31'd0, tick}, 1);
        check_eq("p1_ticks1", {16'd0, ticks}, 1);
        step(1);
        check_eq("p1_tick2", {31'd0, tick}, 1);
        check_eq("p1_ticks2", {16'd0, ticks}, 2);
        step(65532);
        check_eq("p1_ticks_fffe", {16'd0, ticks}, 32'h0000FFFE);
        step(1);
        check_eq("p1_ticks_ffff", {16'd0, ticks}, 32'h0000FFFF);
        step(5);
        check_eq("p1_ticks_sat", {16'd0, ticks}, 32'h0000FFFF);
        check_eq("p1_tick_sat", {31'd0, tick}, 1);
        check_eq("p1_count_sat", count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/timer_ctrl.md
TIMER_CTRL -- requirements
Module: timer_ctrl

Interface
REQ-001 clk  in  1  rising-edge clock; sole clock of the block.
REQ-002 reset  in  1  synchronous, active-high reset, sampled on posedge clk.
REQ-003 cfg_valid  in  1  configuration offer.
REQ-004 cfg_ready  out  1  block accepts configuration; high only in IDLE.
REQ-005 cfg_period  in  32  period in cycles, unsigned.
REQ-006 cfg_oneshot  in  1  1 = one-shot mode; 0 = periodic mode.
REQ-007 start  in  1  single-cycle start/restart command.
REQ-008 stop  in  1  single-cycle abort command.
REQ-009 tick  out  1  registered, one-cycle pulse on period completion.
REQ-010 busy  out  1  high while in RUN.
REQ-011 count  out  32  current counter value (q), registered.
REQ-012 ticks  out  16  completed-period count, saturating.

Function
REQ-013 States SHALL be IDLE, RUN and DONE, encoded in one state register.
REQ-014 Configuration handshake: on a posedge with cfg_valid & cfg_ready, the block SHALL latch period_r <= cfg_period and oneshot_r <= cfg_oneshot.
REQ-015 In RUN and DONE, cfg_ready SHALL be 0 and cfg_valid SHALL be ignored.
REQ-016 IDLE, start=1, stop=0, period_r!=0: next state RUN, count <= 0, ticks <= 0.
REQ-017 IDLE, start=1, period_r==0: start SHALL be ignored; state, count and ticks unchanged.
REQ-018 RUN, count != period_r-1: count SHALL increment by 1 per cycle.
REQ-019 RUN, count == period_r-1, periodic mode:
- count <= 0 and tick <= 1 on the same edge.
- State stays RUN.
REQ-020 RUN, count == period_r-1, one-shot mode:
- tick <= 1 and next state DONE.
- count holds at period_r-1, with no wrap.
REQ-021 tick SHALL be 0 on every edge not covered by REQ-019/REQ-020; it is never high for two consecutive cycles unless period_r==1 in periodic mode.
REQ-022 period_r==1, periodic mode: count stays 0 and tick SHALL be high every cycle from the second RUN cycle onward.
REQ-023 ticks SHALL increment on every edge that sets tick, saturating at 16'hFFFF (no wrap).
REQ-024 RUN, stop=1: next state IDLE; count and ticks SHALL hold their values for readback; tick <= 0.
REQ-025 DONE, start=1, stop=0: next state RUN, count <= 0; ticks retained, not cleared.
REQ-026 DONE, stop=1: next state IDLE; count and ticks hold.
REQ-027 DONE with neither start nor stop: state and count SHALL hold indefinitely.
REQ-028 start and stop asserted in the same cycle: stop SHALL win in RUN and DONE; in IDLE both SHALL be ignored.
REQ-029 start in RUN SHALL be ignored (no restart mid-period).
REQ-030 Period completion coinciding with stop in RUN: stop wins; no tick is issued and ticks is not incremented.
REQ-031 busy SHALL equal (state==RUN) and is decoded from the registered state.
REQ-032 All arithmetic is unsigned and modulo-free; count never exceeds period_r-1 while in RUN or DONE.

Reset
REQ-033 reset=1 at a posedge SHALL force:
- state IDLE
- count=0, ticks=0, tick=0, busy=0, cfg_ready=1
- period_r=0, oneshot_r=0
REQ-034 reset SHALL override every other input in the same cycle, including reset asserted mid-RUN or mid-handshake.
REQ-035 After reset, a start with no prior configuration SHALL be ignored per REQ-017.

Verification
REQ-036 Reset for 3 cycles, then start with no configuration -> busy stays 0, count=0, ticks=0 for 10 cycles.
REQ-037 Configure period=5, periodic; start; run 200 cycles -> count sequence 0,1,2,3,4,0,...; tick high exactly when count returns to 0; ticks=40 after 200 RUN cycles.
REQ-038 Configure period=4, one-shot; start -> single tick at the 4th edge after start; state DONE; count holds 3; busy=0; a second start -> one more tick; ticks=2.
REQ-039 Configure period=10, periodic; start; stop at count=6 -> IDLE, count holds 6; cfg_ready=1; cfg_valid during RUN was not accepted (period_r still 10).
REQ-040 Configure period=1, periodic; start -> tick high every cycle; ticks saturates at 16'hFFFF after 65535 ticks and stays there.
REQ-041 Assert start and stop together in RUN -> IDLE. Assert reset mid-RUN with period=8 -> all outputs at REQ-033 values on the next cycle.
